// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan reader: digit count,
// active-low {g,f,e,d,c,b,a} glyph patterns and segment bit positions.
package ssd_pkg;

   localparam int NUM_DIGITS = 4;

   localparam int SEG_IDX_A = 0;
   localparam int SEG_IDX_B = 1;
   localparam int SEG_IDX_C = 2;
   localparam int SEG_IDX_D = 3;
   localparam int SEG_IDX_E = 4;
   localparam int SEG_IDX_F = 5;
   localparam int SEG_IDX_G = 6;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   // Index of the set bit of a one-hot digit select.
   function automatic logic [1:0] onehot_to_idx(input logic [NUM_DIGITS-1:0] oh);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ssd_scan_reader_if.sv
// Display-side bus of the scan reader: multiplexed segment/select inputs
// and the decoded frame outputs.
interface ssd_scan_reader_if;
   // No backpressure: seg/an are sampled every cycle; frame_done is a
   // one-cycle strobe marking that digit_*/valid/err have just been updated.
   logic [6:0] seg;
   logic [3:0] an;
   logic [3:0] digit_0;
   logic [3:0] digit_1;
   logic [3:0] digit_2;
   logic [3:0] digit_3;
   logic       valid;
   logic       err;
   logic       frame_done;

   modport slave (
      input  seg, an,
      output digit_0, digit_1, digit_2, digit_3, valid, err, frame_done
   );

   modport master (
      output seg, an,
      input  digit_0, digit_1, digit_2, digit_3, valid, err, frame_done
   );
endinterface

// File: rtl/ssd_pattern_decode.sv
// Combinational seven-segment pattern to digit decoder.
// Define SSD_READER_HEX_EN to also accept the A-F glyphs (values 10-15).
module ssd_pattern_decode
   import ssd_pkg::*;
(
   input  logic [6:0] seg,
   output logic       ok,
   output logic [3:0] value
);

   always_comb begin
      ok    = 1'b1;
      value = 4'd0;
      case (seg)
         SEG_0: value = 4'd0;
         SEG_1: value = 4'd1;
         SEG_2: value = 4'd2;
         SEG_3: value = 4'd3;
         SEG_4: value = 4'd4;
         SEG_5: value = 4'd5;
         SEG_6: value = 4'd6;
         SEG_7: value = 4'd7;
         SEG_8: value = 4'd8;
         SEG_9: value = 4'd9;
`ifdef SSD_READER_HEX_EN
         SEG_A: value = 4'd10;
         SEG_B: value = 4'd11;
         SEG_C: value = 4'd12;
         SEG_D: value = 4'd13;
         SEG_E: value = 4'd14;
         SEG_F: value = 4'd15;
`endif
         default: begin
            ok    = 1'b0;
            value = 4'd0;
         end
      endcase
   end

endmodule

// File: rtl/ssd_scan_reader.sv
// Samples a multiplexed four-digit seven-segment bus, filters each dwell for
// stability and publishes complete frames. Hex glyphs via SSD_READER_HEX_EN.
module ssd_scan_reader
   import ssd_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic CLK,
   input  logic RST,
   ssd_scan_reader_if.slave bus
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] RUN_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] RUN_ONE = CW'(1);

   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [CW-1:0]         run_q, run_d;
   logic [3:0]            shadow_q [NUM_DIGITS];
   logic [3:0]            shadow_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] seen_q, seen_d;
   logic                  frame_bad_q, frame_bad_d;
   logic [3:0]            digit_q [NUM_DIGITS];
   logic [3:0]            digit_d [NUM_DIGITS];
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic                  frame_done_q, frame_done_d;

   logic       an_onehot;
   logic       same;
   logic       capture;
   logic [1:0] cap_idx;
   logic       dec_ok;
   logic [3:0] dec_value;

   ssd_pattern_decode u_decode (
      .seg   (bus.seg),
      .ok    (dec_ok),
      .value (dec_value)
   );

   always_comb begin
      seg_d        = bus.seg;
      an_d         = bus.an;
      shadow_d     = shadow_q;
      seen_d       = seen_q;
      frame_bad_d  = frame_bad_q;
      digit_d      = digit_q;
      valid_d      = valid_q;
      err_d        = err_q;
      frame_done_d = 1'b0;

      an_onehot = (bus.an != '0) && ((bus.an & (bus.an - 4'd1)) == '0);
      same      = (bus.an == an_q) && (bus.seg == seg_q);
      cap_idx   = onehot_to_idx(bus.an);

      if (an_onehot && same) begin
         run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_ONE;
      end else if (an_onehot) begin
         run_d = RUN_ONE;
      end else begin
         run_d = '0;
      end

      // A held dwell stays saturated at RUN_MAX, so only the first arrival captures.
      capture = (run_d == RUN_MAX) && !(same && (run_q == RUN_MAX));

      if (capture) begin
         shadow_d[cap_idx] = dec_value;
         seen_d            = seen_q | bus.an;
         frame_bad_d       = frame_bad_q | ~dec_ok;
      end

      if (capture && (seen_d == '1)) begin
         frame_done_d = 1'b1;
         if (!frame_bad_d) begin
            digit_d = shadow_d;
            valid_d = 1'b1;
            err_d   = 1'b0;
         end else begin
            valid_d = 1'b0;
            err_d   = 1'b1;
         end
         for (int i = 0; i < NUM_DIGITS; i++) shadow_d[i] = '0;
         seen_d      = '0;
         frame_bad_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         seg_q        <= '0;
         an_q         <= '0;
         run_q        <= '0;
         seen_q       <= '0;
         frame_bad_q  <= 1'b0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_q[i] <= '0;
            digit_q[i]  <= '0;
         end
      end else begin
         seg_q        <= seg_d;
         an_q         <= an_d;
         run_q        <= run_d;
         seen_q       <= seen_d;
         frame_bad_q  <= frame_bad_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
         frame_done_q <= frame_done_d;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_q[i] <= shadow_d[i];
            digit_q[i]  <= digit_d[i];
         end
      end
   end

   assign bus.digit_0    = digit_q[0];
   assign bus.digit_1    = digit_q[1];
   assign bus.digit_2    = digit_q[2];
   assign bus.digit_3    = digit_q[3];
   assign bus.valid      = valid_q;
   assign bus.err        = err_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_reader.sv
// Bench for ssd_scan_reader: directed dwell table, reset corner case and
// random scans checked cycle by cycle against a run-length reference model.
module tb_ssd_scan_reader;
   import ssd_pkg::*;

   localparam int SC = 4;
`ifdef SSD_READER_HEX_EN
   localparam bit HEX = 1'b1;
`else
   localparam bit HEX = 1'b0;
`endif

   localparam logic [6:0] REF_PATS [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // ---------------- clock / reset / DUT ----------------
   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   ssd_scan_reader_if bus ();

   ssd_scan_reader #(.STABLE_CYCLES(SC)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;
   logic [17:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [18:0] dut_out();
      return {bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0,
              bus.valid, bus.err, bus.frame_done};
   endfunction

   // ---------------- reference model ----------------
   logic [3:0]  m_prev_an;
   logic [6:0]  m_prev_seg;
   int          m_run;
   logic [3:0]  m_seen;
   logic [3:0]  m_shadow [4];
   logic        m_bad;
   logic [15:0] m_digits;
   logic        m_valid, m_err, m_done;

   function automatic logic [4:0] ref_decode(input logic [6:0] s);
      for (int i = 0; i < 16; i++) begin
         if (s == REF_PATS[i] && (i < 10 || HEX)) return {1'b1, 4'(i)};
      end
      return 5'b0;
   endfunction

   function automatic void model_reset();
      m_prev_an = '0; m_prev_seg = '0; m_run = 0; m_seen = '0; m_bad = 1'b0;
      m_digits = '0; m_valid = 1'b0; m_err = 1'b0; m_done = 1'b0;
      for (int i = 0; i < 4; i++) m_shadow[i] = '0;
   endfunction

   function automatic void model_step(input logic [3:0] an, input logic [6:0] seg);
      int idx;
      logic [4:0] dec;
      bit oh;
      oh = ($countones(an) == 1);
      if (oh && an == m_prev_an && seg == m_prev_seg) m_run++;
      else m_run = oh ? 1 : 0;
      m_prev_an = an;
      m_prev_seg = seg;
      m_done = 1'b0;
      if (m_run == SC) begin
         idx = 0;
         for (int i = 0; i < 4; i++) if (an[i]) idx = i;
         dec = ref_decode(seg);
         m_shadow[idx] = dec[3:0];
         m_seen[idx] = 1'b1;
         if (!dec[4]) m_bad = 1'b1;
         if (m_seen == 4'hF) begin
            m_done = 1'b1;
            if (!m_bad) begin
               m_digits = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
               m_valid = 1'b1;
               m_err = 1'b0;
            end else begin
               m_valid = 1'b0;
               m_err = 1'b1;
            end
            exp_q.push_back({m_digits, m_valid, m_err});
            m_seen = '0;
            m_bad = 1'b0;
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step(input logic [3:0] an, input logic [6:0] seg);
      bus.an = an;
      bus.seg = seg;
      @(posedge CLK);
      model_step(an, seg);
      #1;
      check("cycle_vs_model", 32'(dut_out()), 32'({m_digits, m_valid, m_err, m_done}));
      if (bus.frame_done) begin
         check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0)
            check("frame_content", 32'({bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0,
                                        bus.valid, bus.err}), 32'(exp_q.pop_front()));
      end
   endtask

   task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n);
      repeat (n) step(an, seg);
   endtask

   task automatic do_reset();
      RST = 1'b0;
      bus.an = '0;
      bus.seg = '0;
      #1;
      check("reset_outputs_async", 32'(dut_out()), 32'd0);
      repeat (2) @(posedge CLK);
      model_reset();
      exp_q.delete();
      @(negedge CLK);
      RST = 1'b1;
      check("reset_outputs", 32'(dut_out()), 32'd0);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      int          cycles;
      logic [15:0] digits;
      logic        valid;
      logic        err;
      logic        done;
   } vec_t;

   vec_t vecs [$];

   task automatic add(input logic [3:0] an, input logic [6:0] seg, input int n,
                      input logic [15:0] d, input logic v, input logic e, input logic fd);
      vec_t r;
      r.an = an; r.seg = seg; r.cycles = n; r.digits = d; r.valid = v; r.err = e; r.done = fd;
      vecs.push_back(r);
   endtask

   initial begin
      logic [3:0] r_an;
      logic [6:0] r_seg;

      do_reset();

      // basic frame 1,2,3,4
      add(4'b0001, 7'b1111001, 4, 16'h0000, 0, 0, 0);
      add(4'b0010, 7'b0100100, 4, 16'h0000, 0, 0, 0);
      add(4'b0100, 7'b0110000, 4, 16'h0000, 0, 0, 0);
      add(4'b1000, 7'b0011001, 4, 16'h4321, 1, 0, 1);
      add(4'b0000, 7'b1111111, 1, 16'h4321, 1, 0, 0);
      // short dwell on digit 2, completed later
      add(4'b0001, 7'b0010010, 4, 16'h4321, 1, 0, 0);
      add(4'b0010, 7'b0000010, 4, 16'h4321, 1, 0, 0);
      add(4'b0100, 7'b1111000, 3, 16'h4321, 1, 0, 0);
      add(4'b1000, 7'b0000000, 4, 16'h4321, 1, 0, 0);
      add(4'b0100, 7'b1111000, 4, 16'h8765, 1, 0, 1);
      // undecodable digit 2
      add(4'b0001, 7'b1000000, 4, 16'h8765, 1, 0, 0);
      add(4'b0010, 7'b0010000, 4, 16'h8765, 1, 0, 0);
      add(4'b0100, 7'b1111111, 4, 16'h8765, 1, 0, 0);
      add(4'b1000, 7'b1111001, 4, 16'h8765, 0, 1, 1);
      // selects that are not one-hot never capture
      add(4'b0011, 7'b1111001, 20, 16'h8765, 0, 1, 0);
      add(4'b0000, 7'b1111001, 20, 16'h8765, 0, 1, 0);
      // long hold captures once
      add(4'b0001, 7'b0110000, 12, 16'h8765, 0, 1, 0);
      add(4'b0010, 7'b0010000, 4, 16'h8765, 0, 1, 0);
      add(4'b0100, 7'b0000000, 4, 16'h8765, 0, 1, 0);
      add(4'b1000, 7'b1111000, 4, 16'h7893, 1, 0, 1);
      // re-capture of digit 0 overwrites
      add(4'b0001, 7'b0010010, 4, 16'h7893, 1, 0, 0);
      add(4'b0001, 7'b0000010, 4, 16'h7893, 1, 0, 0);
      add(4'b0010, 7'b1000000, 4, 16'h7893, 1, 0, 0);
      add(4'b0100, 7'b1000000, 4, 16'h7893, 1, 0, 0);
      add(4'b1000, 7'b1111001, 4, 16'h1006, 1, 0, 1);
      // hex glyph A on digit 0
      add(4'b0001, 7'b0001000, 4, 16'h1006, 1, 0, 0);
      add(4'b0010, 7'b0100100, 4, 16'h1006, 1, 0, 0);
      add(4'b0100, 7'b0110000, 4, 16'h1006, 1, 0, 0);
      if (HEX) add(4'b1000, 7'b0011001, 4, 16'h432A, 1, 0, 1);
      else     add(4'b1000, 7'b0011001, 4, 16'h1006, 0, 1, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         dwell(vecs[i].an, vecs[i].seg, vecs[i].cycles);
         check($sformatf("vec%0d", i), 32'(dut_out()),
               32'({vecs[i].digits, vecs[i].valid, vecs[i].err, vecs[i].done}));
      end

      // reset in the middle of a frame discards the partial frame
      dwell(4'b0001, 7'b1111001, 4);
      dwell(4'b0010, 7'b0100100, 4);
      do_reset();
      dwell(4'b0100, 7'b0110000, 4);
      dwell(4'b1000, 7'b0011001, 4);
      check("post_reset_no_frame", 32'(dut_out()), 32'd0);
      dwell(4'b0001, 7'b1111001, 4);
      dwell(4'b0010, 7'b0100100, 3);
      check("latency_minus_one", 32'(bus.frame_done), 32'd0);
      step(4'b0010, 7'b0100100);
      check("post_reset_frame", 32'(dut_out()), 32'({16'h4321, 1'b1, 1'b0, 1'b1}));
      step(4'b0010, 7'b0100100);
      check("done_one_cycle", 32'(bus.frame_done), 32'd0);

      // random scans
      for (int k = 0; k < 300; k++) begin
         case ($urandom_range(0, 9))
            0:       r_an = 4'b0000;
            1:       r_an = 4'($urandom_range(0, 15));
            default: r_an = 4'(1 << $urandom_range(0, 3));
         endcase
         if ($urandom_range(0, 9) == 0) r_seg = 7'($urandom_range(0, 127));
         else                           r_seg = REF_PATS[$urandom_range(0, 15)];
         dwell(r_an, r_seg, $urandom_range(1, 7));
      end

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ssd_scan_reader.md
# ssd_scan_reader

Receive-side counterpart of the chronometer's seven-segment outputs. The block samples a time-multiplexed four-digit seven-segment bus, made of one segment pattern plus a one-hot digit select. It filters each digit's dwell for stability, decodes the pattern back to a 4-bit digit value, and presents a complete, consistent four-digit frame with valid/error status. It sits on the capture side of a display link, for example in a self-checking harness or a board that snoops an external display.

## Interface
- STABLE_CYCLES, 4: consecutive identical cycles required before a digit is captured; legal range ≥1.
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; one clock; reset is asynchronous and active-low.
- seg  in  7  segment pattern, bit order {g,f,e,d,c,b,a}, active-low (0 = lit).
- an  in  4  digit select, active-high, one-hot; an[i] selects digit i.
- digit_0..digit_3  out  4 each  decoded digits of the last good frame.
- valid  out  1  high once a frame has been accepted with no decode error.
- err  out  1  high when the most recently completed frame contained an undecodable pattern.
- frame_done  out  1  one-cycle pulse on every frame completion, good or bad.

## Operation
- Input stage: seg and an are registered each cycle into seg_q and an_q.
- Run counter:
  - Increments, saturating at STABLE_CYCLES, while an is one-hot and {an,seg} == {an_q,seg_q}.
  - Otherwise loads 1 if an is one-hot, or 0 if an is not one-hot (all-zero or multi-hot).
- Capture: fires on the edge where the run length (counting the current cycle) first equals STABLE_CYCLES. It fires exactly once per dwell.
  - Decode seg and write the result into shadow[i], where i is the index of an.
  - Set seen[i].
  - OR the decode failure into frame_bad.
- Re-capture of a digit already seen in the current frame overwrites shadow[i].
- Frame completion: on the edge where seen becomes 4'b1111, counting the capture in progress:
  - If the frame is good: digit_i ← shadow (including this capture), valid←1, err←0.
  - If the frame is bad: digits hold their previous values, valid←0, err←1.
  - In both cases frame_done←1 for one cycle, then seen, frame_bad and shadow clear.
- Digit order is free. Frames need not be contiguous.
- Decode table (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other pattern is a decode failure.
- Reset mid-operation clears everything, including a partly collected frame.

## Timing
- Reset values: digit_0..3=0, valid=0, err=0, frame_done=0. Internal seg_q, an_q, run counter, shadow, seen and frame_bad are all 0.
- Counter width is $clog2(STABLE_CYCLES+1).
- Outputs change only on frame completion. They are registered, with no combinational path from seg/an to any output.
- Latency: if the final digit's dwell starts at cycle t, the new digits and frame_done appear at cycle t+STABLE_CYCLES.
- Dwell shorter than STABLE_CYCLES: no capture.
- A dwell held indefinitely captures only once.
- A segment change within the same an restarts the run at 1.

## Configuration
- SSD_READER_HEX_EN defined: patterns A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 decode to 10–15.
- SSD_READER_HEX_EN undefined: those patterns are decode failures.

## Structure
- Package ssd_pkg holds:
  - the NUM_DIGITS=4 constant;
  - the segment pattern constants SEG_0..SEG_9 and SEG_A..SEG_F;
  - the segment bit-index constants.
- Sub-module ssd_pattern_decode: combinational, seg → {ok, value[3:0]}. It contains the SSD_READER_HEX_EN guard.

## Test plan
All scenarios use STABLE_CYCLES=4.
- Reset asserted mid-frame, then released -> all outputs 0; the next frame needs all four digits again.
- Scan an=0001/1111001, 0010/0100100, 0100/0110000, 1000/0011001, 4 cycles each -> digits 1,2,3,4; valid=1, err=0; frame_done high exactly one cycle, 4 cycles after the final dwell starts.
- Same scan with the digit-2 dwell only 3 cycles -> no frame_done; a later 4-cycle dwell on digit 2 completes the frame.
- Digit 2 pattern 1111111 held 4 cycles in an otherwise good frame -> err=1, valid=0, digits unchanged from the previous frame, frame_done pulses.
- an=0011 or an=0000 held 20 cycles with a valid pattern -> no capture, no frame_done.
- seg=0001000 on digit 0 in a full frame -> with SSD_READER_HEX_EN, digit_0=10 and valid=1; without it, err=1.
